// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared constants and load FSM encoding for the instruction memory
package inst_mem_pkg;
  localparam int INST_LEN_DEF = 32;
  localparam logic [INST_LEN_DEF-1:0] INST_NOP = '0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DONE = 2'd2} state_e;
endpackage

// File: rtl/inst_mem_stream_loader_if.sv
// inst_mem_stream_loader_if: host load stream plus core fetch port of the instruction memory
interface inst_mem_stream_loader_if #(parameter int INST_LEN = 32, parameter int ADDR_W = 16);
  logic                i_load_start;
  logic [INST_LEN-1:0] i_load_data;
  logic                i_load_valid;
  logic                i_load_last;
  logic                o_load_ready;
  logic [ADDR_W:0]     o_load_count;
  logic                o_load_done;
  logic                o_load_ovf;
  logic [INST_LEN-1:0] i_PC;
  logic                i_rd_en;
  logic [INST_LEN-1:0] o_instruction;
  logic                o_inst_valid;
  logic                o_pc_fault;
  modport master (
    output i_load_start, i_load_data, i_load_valid, i_load_last, i_PC, i_rd_en,
    input  o_load_ready, o_load_count, o_load_done, o_load_ovf, o_instruction, o_inst_valid, o_pc_fault
  );
  modport slave (
    input  i_load_start, i_load_data, i_load_valid, i_load_last, i_PC, i_rd_en,
    output o_load_ready, o_load_count, o_load_done, o_load_ovf, o_instruction, o_inst_valid, o_pc_fault
  );
endinterface

// File: rtl/inst_mem_stream_loader_sdp_ram.sv
// sdp_ram: one synchronous write port, one asynchronous read port
module sdp_ram #(
  parameter int DW    = 32,
  parameter int AW    = 16,
  parameter int DEPTH = 65536
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr[IW-1:0]] <= wdata;
  // Reads beyond DEPTH return zero; the caller masks them as faults anyway
  assign rdata = int'(raddr) < DEPTH ? mem[raddr[IW-1:0]] : '0;
endmodule

// File: rtl/inst_mem_stream_loader.sv
// inst_mem_stream_loader: stream-loaded instruction memory with PC-addressed, fault-checked fetch
module inst_mem_stream_loader
  import inst_mem_pkg::*;
#(
  parameter int INST_LEN   = INST_LEN_DEF,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 65536,
  parameter int RD_LATENCY = 0,
  parameter int PC_SHIFT   = 2
) (
  input logic                    i_sys_clk,
  input logic                    i_sys_rst,
  inst_mem_stream_loader_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                we, loading, done, fault_c, valid_c;
  logic [ADDR_W-1:0]   raddr;
  logic [INST_LEN-1:0] rdata, inst_c;
  assign loading = state_q == ST_LOAD;
  assign done    = state_q == ST_DONE;
  // The word count doubles as the write pointer; it saturates at DEPTH
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    we      = 1'b0;
    if (bus.i_load_start) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (loading && bus.i_load_valid) begin
      we      = cnt_q < DEPTH_C;
      cnt_d   = we ? cnt_q + 1'b1 : cnt_q;
      ovf_d   = ovf_q | ~we;
      state_d = bus.i_load_last ? ST_DONE : ST_LOAD;
    end
  end
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  sdp_ram #(.DW(INST_LEN), .AW(ADDR_W), .DEPTH(DEPTH)) u_ram (
    .clk   (i_sys_clk),
    .we    (we),
    .waddr (cnt_q[ADDR_W-1:0]),
    .wdata (bus.i_load_data),
    .raddr (raddr),
    .rdata (rdata)
  );
  assign raddr   = bus.i_PC[PC_SHIFT+ADDR_W-1:PC_SHIFT];
  assign fault_c = done && ((|bus.i_PC[PC_SHIFT-1:0]) || {1'b0, raddr} >= cnt_q);
  assign valid_c = done && !fault_c;
  assign inst_c  = valid_c ? rdata : INST_LEN'(INST_NOP);
  assign bus.o_load_ready = loading;
  assign bus.o_load_count = cnt_q;
  assign bus.o_load_done  = done;
  assign bus.o_load_ovf   = ovf_q;
  if (RD_LATENCY == 1) begin : g_reg
    logic [INST_LEN-1:0] inst_q, inst_d;
    logic                valid_q, valid_d, fault_q, fault_d;
    always_comb begin
      inst_d  = bus.i_load_start ? INST_LEN'(INST_NOP) : bus.i_rd_en ? inst_c : inst_q;
      valid_d = bus.i_load_start ? 1'b0 : bus.i_rd_en ? valid_c : valid_q;
      fault_d = bus.i_load_start ? 1'b0 : bus.i_rd_en ? fault_c : fault_q;
    end
    always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
        inst_q  <= INST_LEN'(INST_NOP);
        valid_q <= 1'b0;
        fault_q <= 1'b0;
      end else begin
        inst_q  <= inst_d;
        valid_q <= valid_d;
        fault_q <= fault_d;
      end
    end
    assign bus.o_instruction = inst_q;
    assign bus.o_inst_valid  = valid_q;
    assign bus.o_pc_fault    = fault_q;
  end else begin : g_comb
    assign bus.o_instruction = inst_c;
    assign bus.o_inst_valid  = valid_c;
    assign bus.o_pc_fault    = fault_c;
  end
endmodule

// File: tb/tb_inst_mem_stream_loader.sv
// tb_inst_mem_stream_loader: directed and random load/fetch traffic against a behavioural model
module tb_inst_mem_stream_loader;
  localparam int DEP = 8;
  logic        clk = 1'b0, rst = 1'b1;
  logic        s_start = 1'b0, s_valid = 1'b0, s_last = 1'b0, s_rd_en = 1'b0;
  logic [31:0] s_data = '0, s_pc = '0;
  int          errs = 0, checks = 0;
  int          phase = 0, m_cnt = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_mem [DEP];
  logic [31:0] r_inst = '0;
  bit          r_valid = 1'b0, r_fault = 1'b0;
  int          n;
  inst_mem_stream_loader_if #(.INST_LEN(32), .ADDR_W(16)) b0 ();
  inst_mem_stream_loader_if #(.INST_LEN(32), .ADDR_W(16)) b1 ();
  assign b0.i_load_start = s_start;
  assign b0.i_load_data  = s_data;
  assign b0.i_load_valid = s_valid;
  assign b0.i_load_last  = s_last;
  assign b0.i_PC         = s_pc;
  assign b0.i_rd_en      = s_rd_en;
  assign b1.i_load_start = s_start;
  assign b1.i_load_data  = s_data;
  assign b1.i_load_valid = s_valid;
  assign b1.i_load_last  = s_last;
  assign b1.i_PC         = s_pc;
  assign b1.i_rd_en      = s_rd_en;
  inst_mem_stream_loader #(.DEPTH(DEP), .RD_LATENCY(0)) u_dut0 (.i_sys_clk(clk), .i_sys_rst(rst), .bus(b0.slave));
  inst_mem_stream_loader #(.DEPTH(DEP), .RD_LATENCY(1)) u_dut1 (.i_sys_clk(clk), .i_sys_rst(rst), .bus(b1.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic exp_fetch(output logic [31:0] i, output bit v, output bit f);
    int w;
    w = (s_pc >> 2) & 32'hffff;
    f = phase == 2 && (s_pc[1:0] != 2'b00 || w >= m_cnt);
    v = phase == 2 && !f;
    i = v ? m_mem[w] : 32'h0;
  endtask
  task automatic model_edge();
    logic [31:0] ci;
    bit cv, cf;
    exp_fetch(ci, cv, cf);
    if (rst) begin
      phase = 0; m_cnt = 0; m_ovf = 1'b0;
      r_inst = '0; r_valid = 1'b0; r_fault = 1'b0;
    end else begin
      if (s_rd_en) begin r_inst = ci; r_valid = cv; r_fault = cf; end
      if (s_start) begin
        phase = 1; m_cnt = 0; m_ovf = 1'b0;
        r_inst = '0; r_valid = 1'b0; r_fault = 1'b0;
      end else if (phase == 1 && s_valid) begin
        if (m_cnt < DEP) begin m_mem[m_cnt] = s_data; m_cnt++; end
        else m_ovf = 1'b1;
        if (s_last) phase = 2;
      end
    end
  endtask
  task automatic compare_all();
    logic [31:0] ci;
    bit cv, cf;
    exp_fetch(ci, cv, cf);
    chk("count0", b0.o_load_count, m_cnt);
    chk("count1", b1.o_load_count, m_cnt);
    chk("done", {b0.o_load_done, b1.o_load_done}, {2{phase == 2}});
    chk("ready", {b0.o_load_ready, b1.o_load_ready}, {2{phase == 1}});
    chk("ovf", {b0.o_load_ovf, b1.o_load_ovf}, {2{m_ovf}});
    chk("inst0", b0.o_instruction, ci);
    chk("vf0", {b0.o_inst_valid, b0.o_pc_fault}, {cv, cf});
    chk("inst1", b1.o_instruction, r_inst);
    chk("vf1", {b1.o_inst_valid, b1.o_pc_fault}, {r_valid, r_fault});
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask
  task automatic pulse_start();
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
  endtask
  task automatic beat(input logic [31:0] d, input bit l);
    s_valid = 1'b1; s_data = d; s_last = l;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask
  task automatic rand_fetch();
    s_rd_en = 1'($urandom_range(0, 1));
    s_pc = 32'($urandom_range(0, 11)) * 4;
    if ($urandom_range(0, 3) == 0) s_pc = s_pc + 32'($urandom_range(1, 3));
    if ($urandom_range(0, 7) == 0) s_pc = s_pc | 32'h0010_0000;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_count", b0.o_load_count, 0);
    chk("rst_flags", {b1.o_load_done, b1.o_load_ovf, b1.o_load_ready, b1.o_inst_valid}, 4'b0000);
    rst = 1'b0;
    tick();
    pulse_start();
    beat(32'h11, 1'b0); beat(32'h22, 1'b0); beat(32'h33, 1'b0); beat(32'h44, 1'b1);
    chk("t1_count", b0.o_load_count, 4);
    chk("t1_done_ovf", {b0.o_load_done, b0.o_load_ovf}, 2'b10);
    s_pc = 32'h8; s_rd_en = 1'b1;
    tick();
    chk("t1_inst0", {b0.o_inst_valid, b0.o_instruction}, {1'b1, 32'h33});
    chk("t1_inst1", b1.o_instruction, 32'h33);
    s_pc = 32'h10;
    tick();
    chk("t2_oob", {b0.o_pc_fault, b0.o_inst_valid, b0.o_instruction}, {2'b10, 32'h0});
    s_pc = 32'h6;
    tick();
    chk("t2_misalign", b0.o_pc_fault, 1'b1);
    s_pc = 32'h0;
    tick();
    chk("t4_word0", b1.o_instruction, 32'h11);
    s_pc = 32'h4; s_rd_en = 1'b0;
    tick();
    tick();
    chk("t4_hold", b1.o_instruction, 32'h11);
    s_rd_en = 1'b1;
    tick();
    chk("t4_word1", b1.o_instruction, 32'h22);
    pulse_start();
    for (int i = 0; i < 10; i++) beat(32'hA0 + 32'(i), i == 9);
    chk("t3_count", b0.o_load_count, 8);
    chk("t3_done_ovf", {b0.o_load_done, b0.o_load_ovf}, 2'b11);
    s_pc = 32'h1C;
    tick();
    chk("t3_last_word", b0.o_instruction, 32'hA7);
    pulse_start();
    beat(32'h5, 1'b0); beat(32'h6, 1'b0); beat(32'h7, 1'b0);
    pulse_start();
    beat(32'hC1, 1'b0); beat(32'hC2, 1'b1);
    chk("t5_count", b0.o_load_count, 2);
    s_pc = 32'h4;
    tick();
    chk("t5_word1", b0.o_instruction, 32'hC2);
    pulse_start();
    beat(32'h9, 1'b0); beat(32'hA, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_after_rst", {b0.o_load_ready, b0.o_load_done, b0.o_instruction}, {2'b00, 32'h0});
    chk("t6_count", b0.o_load_count, 0);
    s_valid = 1'b1;
    tick();
    tick();
    s_valid = 1'b0;
    chk("t6_ignored", b0.o_load_count, 0);
    for (int it = 0; it < 30; it++) begin
      n = $urandom_range(1, 12);
      pulse_start();
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin
          s_data = $urandom; s_last = 1'($urandom_range(0, 1));
          rand_fetch();
          tick();
          s_last = 1'b0;
        end
        if (k == 2 && $urandom_range(0, 7) == 0) pulse_start();
        rand_fetch();
        beat($urandom, k == n - 1);
      end
      repeat (15) begin
        rand_fetch();
        tick();
      end
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
